// File: rtl/fmem_pkg.sv
// Shared types and constants for the FMEM coefficient ROM read path.
package fmem_pkg;

    localparam int FMEM_DEPTH  = 16;
    localparam int FMEM_ADDR_W = 4;
    localparam int FMEM_DATA_W = 32;

    typedef logic signed [FMEM_DATA_W-1:0] fmem_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fmem_rd_state_t;

    typedef struct packed {
        fmem_word_t data;
        logic       last;
    } fmem_entry_t;

endpackage

// File: rtl/fmem_reader_if.sv
// Coefficient stream from the FMEM reader to the convolution MAC.
interface fmem_reader_if
    import fmem_pkg::*;
#(
    parameter int DATA_W = FMEM_DATA_W
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input  m_ready);
    modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);
endinterface

// File: rtl/fmem_skid_fifo.sv
// Two-entry FIFO that soaks up words already in flight from the ROM while the MAC stalls.
module fmem_skid_fifo
    import fmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  fmem_entry_t push_entry,
    output fmem_entry_t head,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty
);

    fmem_entry_t mem [2];
    logic        rd_ptr;
    logic        wr_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // Push into a full FIFO only happens alongside a pop, so the slot being overwritten is the head leaving.
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/fmem_reader.sv
// Sweeps the FMEM ROM for a programmed number of passes and streams coefficients to the MAC.
//   state | meaning
//   IDLE  | waiting for start; done pulses here for one cycle after a job
//   RUN   | issuing ROM reads, addresses 0..DEPTH-1 per pass
//   DRAIN | last read issued; waiting for in-flight and buffered words to leave
module fmem_reader
    import fmem_pkg::*;
#(
    parameter int DEPTH  = FMEM_DEPTH,
    parameter int ADDR_W = FMEM_ADDR_W,
    parameter int DATA_W = FMEM_DATA_W,
    parameter int PASS_W = 8
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PASS_W-1:0] num_passes,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    fmem_reader_if.master     m,
    output logic              busy,
    output logic              done
);

    fmem_rd_state_t    state;
    fmem_rd_state_t    state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [PASS_W-1:0] passes_left;
    logic              pending;
    logic              tag;
    logic              issue;
    logic              pop;
    logic              at_end;
    logic              done_nxt;
    logic [2:0]        occupancy;

    fmem_entry_t       push_entry;
    fmem_entry_t       head;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign pop    = m.m_valid && m.m_ready;
    assign at_end = (addr == ADDR_W'(DEPTH - 1));
    // Words owed to the FIFO after this edge; keeping it below 2 means a push always has room.
    assign occupancy = {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (num_passes != '0) begin
                        state_nxt = RUN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                issue = (occupancy < 3'd2);
                if (issue && at_end && (passes_left == PASS_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!pending && fifo_empty) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr        <= '0;
            passes_left <= '0;
            pending     <= 1'b0;
            tag         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done    <= done_nxt;
            pending <= issue;
            if ((state == IDLE) && start && (num_passes != '0)) begin
                passes_left <= num_passes;
                addr        <= '0;
            end else if (issue) begin
                tag <= at_end;
                if (at_end) begin
                    addr        <= '0;
                    passes_left <= passes_left - 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(pending && fifo_full && !pop));
        end
    end

    assign push_entry = {rom_data, tag};

    fmem_skid_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (pending),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign rom_addr  = addr;
    assign busy      = (state != IDLE);
    assign m.m_valid = !fifo_empty;
    assign m.m_data  = head.data;
    assign m.m_last  = head.last;

endmodule

// File: tb/tb_fmem_reader.sv
// Scoreboard bench for fmem_reader: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_fmem_reader;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_passes = '0;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
    logic        busy;
    logic        done;

    fmem_reader_if s_if ();

    fmem_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_passes (num_passes),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m          (s_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [DEPTH] = '{
        32'hFFFF6E96, 32'h00001234, 32'hFFFFF001, 32'h00000ABC,
        32'h7FFFFFFF, 32'h80000000, 32'h00000042, 32'd35919,
        32'hFFFFFFFF, 32'h00010000, 32'h0000BEEF, 32'hFFFE0000,
        32'h00000005, 32'hDEADBEEF, 32'h00C0FFEE, 32'd677
    };

    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   beats = 0;
    int   lasts = 0;
    int   done_cnt = 0;
    int   done_double = 0;
    int   fifo_over = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        done_prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                chk("stall_valid", 64'(s_if.m_valid), 64'd1);
                chk("stall_data", 64'(s_if.m_data), 64'(prev_data));
                chk("stall_last", 64'(s_if.m_last), 64'(prev_last));
            end
            if (s_if.m_valid && s_if.m_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat", s_if.m_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("beat_data", 64'(s_if.m_data), 64'(e.d));
                    chk("beat_last", 64'(s_if.m_last), 64'(e.l));
                end
                beats++;
                if (s_if.m_last) lasts++;
            end
            stall_prev = s_if.m_valid && !s_if.m_ready;
            prev_data  = s_if.m_data;
            prev_last  = s_if.m_last;
            if (dut.u_fifo.count > 2'd2) fifo_over++;
            if (done) begin
                done_cnt++;
                if (done_prev) done_double++;
            end
            done_prev = done;
        end else begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end
    end

    // Drives a one-cycle start; returns just after the edge that samples it.
    task automatic start_job(input int n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        num_passes = 8'(n);
        for (int p = 0; p < n; p++)
            for (int w = 0; w < DEPTH; w++)
                q.push_back('{d: rom[w], l: (w == DEPTH - 1)});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < max), 64'd1);
    endtask

    logic [31:0] pattern = 32'b1011_0010_1110_0101_0011_1001_0100_1101;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bub, b0, l0, d0;
        s_if.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_m_valid", 64'(s_if.m_valid), 64'd0);
        chk("rst_m_data", 64'(s_if.m_data), 64'd0);
        chk("rst_m_last", 64'(s_if.m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;

        // Single pass, full throughput
        b0 = beats; l0 = lasts; d0 = done_cnt;
        start_job(1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_if.m_valid && n < 10);
        chk("t1_latency", 64'(n), 64'd3);
        bub = 0;
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            if (!s_if.m_valid) bub++;
        end
        chk("t1_bubbles", 64'(bub), 64'd0);
        chk("t1_last_on_15", 64'(s_if.m_last), 64'd1);
        @(negedge clk);
        chk("t1_done_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t1_done_single", 64'(done), 64'd0);
        chk("t1_beats", 64'(beats - b0), 64'd16);
        chk("t1_lasts", 64'(lasts - l0), 64'd1);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Three passes back-to-back
        b0 = beats; l0 = lasts; d0 = done_cnt;
        start_job(3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_if.m_valid && n < 10);
        chk("t2_latency", 64'(n), 64'd3);
        bub = 0;
        for (int i = 1; i < 3 * DEPTH; i++) begin
            @(negedge clk);
            if (!s_if.m_valid) bub++;
        end
        chk("t2_bubbles", 64'(bub), 64'd0);
        wait_done(10, "t2_done_timeout");
        repeat (3) @(negedge clk);
        chk("t2_beats", 64'(beats - b0), 64'd48);
        chk("t2_lasts", 64'(lasts - l0), 64'd3);
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_q_empty", 64'(q.size()), 64'd0);

        // Patterned backpressure, two passes
        b0 = beats; l0 = lasts; d0 = done_cnt;
        start_job(2);
        n = 0;
        while (!done && n < 400) begin
            s_if.m_ready = pattern[n % 32];
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_done_timeout", 64'(n < 400), 64'd1);
        s_if.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_beats", 64'(beats - b0), 64'd32);
        chk("t3_lasts", 64'(lasts - l0), 64'd2);
        chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t3_q_empty", 64'(q.size()), 64'd0);
        chk("t3_fifo_over", 64'(fifo_over), 64'd0);

        // Sink held off for 20 cycles
        b0 = beats; d0 = done_cnt;
        s_if.m_ready = 1'b0;
        start_job(1);
        repeat (20) @(negedge clk);
        chk("t4_fifo_count", 64'(dut.u_fifo.count), 64'd2);
        chk("t4_rom_addr_held", 64'(rom_addr), 64'd2);
        chk("t4_head_word0", 64'(s_if.m_data), 64'(rom[0]));
        chk("t4_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        s_if.m_ready = 1'b1;
        wait_done(40, "t4_done_timeout");
        repeat (3) @(negedge clk);
        chk("t4_beats", 64'(beats - b0), 64'd16);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t4_q_empty", 64'(q.size()), 64'd0);

        // Zero passes
        b0 = beats; d0 = done_cnt;
        start_job(0);
        @(negedge clk);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_valid", 64'(s_if.m_valid), 64'd0);
        @(negedge clk);
        chk("t5_done_single", 64'(done), 64'd0);
        repeat (5) @(negedge clk);
        chk("t5_beats", 64'(beats - b0), 64'd0);
        chk("t5_busy_after", 64'(busy), 64'd0);

        // Reset mid-pass, then replay
        b0 = beats; d0 = done_cnt;
        start_job(1);
        n = 0;
        while (beats - b0 < 5 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_5", 64'(beats - b0 >= 5), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        chk("t6_rom_addr", 64'(rom_addr), 64'd0);
        chk("t6_valid", 64'(s_if.m_valid), 64'd0);
        chk("t6_data", 64'(s_if.m_data), 64'd0);
        chk("t6_last", 64'(s_if.m_last), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        b0 = beats;
        start_job(1);
        wait_done(40, "t6_done_timeout");
        repeat (3) @(negedge clk);
        chk("t6_replay_beats", 64'(beats - b0), 64'd16);
        chk("t6_q_empty", 64'(q.size()), 64'd0);
        chk("done_double", 64'(done_double), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fmem_reader.md
Name: fmem_reader

Overview:
- Read-side sequencer for the generated FMEM filter-coefficient ROM.
- On a start pulse it sweeps ROM addresses 0..DEPTH-1 for a programmable number of passes (one pass per convolution window).
- It absorbs the ROM's 1-cycle registered read latency and streams coefficients to the MAC datapath over a valid/ready interface with full backpressure support.
- It sits between the FMEM ROM and the convolution MAC.

Parameters:
- DEPTH, 16, number of filter coefficients (ROM words); power of two not required.
- ADDR_W, 4, ROM address width; must satisfy 2**ADDR_W >= DEPTH.
- DATA_W, 32, coefficient width (signed two's complement, passed through unmodified).
- PASS_W, 8, width of the pass-count input.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_passes  in  PASS_W  number of full sweeps; latched when start is accepted.
- rom_addr  out  ADDR_W  address to the FMEM ROM (the ROM registers its output on clk).
- rom_data  in  DATA_W  ROM output z, valid the cycle after rom_addr is sampled.
- m_data  out  DATA_W  coefficient to the MAC.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept; transfer = m_valid && m_ready.
- m_last  out  1  qualifies m_data as coefficient DEPTH-1 of a pass.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when all passes have been delivered.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, rom_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
  - Reset also clears the FIFO, the pending flag and all counters.
  - Reset mid-operation aborts immediately; no done pulse is generated.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start && num_passes!=0 -> latch passes_left=num_passes, addr=0, go to RUN.
  - start && num_passes==0 -> done=1 next cycle, stay in IDLE.
- RUN, issue rule: an issue occurs in a cycle when (fifo_count + pending - pop) < 2, where pop = m_valid && m_ready.
  - On issue: pending<=1, tag<=(addr==DEPTH-1), and addr advances at the same edge. The ROM samples rom_addr at that edge.
  - No issue: pending<=0 and addr holds.
- Capture: when pending==1, the next edge pushes {rom_data, tag} into a 2-entry FIFO.
- Output: m_data, m_valid and m_last come from the FIFO head.
  - They must stay stable while m_valid && !m_ready.
  - Simultaneous push and pop on a full FIFO is legal; on an empty FIFO, push then pop on later cycles.
- Wrap: an issue with addr==DEPTH-1 sets addr<=0 and decrements passes_left.
  - If passes_left was 1, go to DRAIN instead (no further issues).
- DRAIN: when pending==0 && fifo_count==0 -> IDLE, with done=1 for exactly one cycle (the first IDLE cycle).
  - busy deasserts in that same cycle.
- start while busy: ignored; num_passes is not re-latched.
- Latency: with m_ready=1, start sampled at edge E0 -> first m_valid in cycle 3 after the start cycle.
- Throughput: steady state is 1 word/cycle with m_ready=1; no bubbles at pass wrap.
- Backpressure: m_ready=0 indefinitely -> at most 2 words buffered and no further issues. No word is lost or duplicated.
- Ordering: words emerge strictly in address order, passes back-to-back. Exactly DEPTH*num_passes transfers occur, with num_passes m_last beats.

Decomposition:
- Shared package fmem_pkg:
  - FMEM_DEPTH, FMEM_ADDR_W, FMEM_DATA_W constants.
  - typedef fmem_word_t (logic signed [DATA_W-1:0]).
  - typedef enum fmem_rd_state_t {IDLE, RUN, DRAIN}.
  - struct fmem_entry_t {data, last}.
- One sub-module: fmem_skid_fifo, a 2-entry FIFO with push, pop, count, head and full/empty flags.
- FSM, address counter, pass counter and issue logic live in fmem_reader.

Test Plan:
- Single pass, m_ready=1, num_passes=1:
  - 16 consecutive beats: word0=0xFFFF6E96 (-37226), word7=35919, word15=677.
  - m_last only on word15; done pulse one cycle after the DRAIN empty condition.
  - First m_valid 3 cycles after start.
- Three passes, m_ready=1:
  - 48 beats with no bubbles; m_last on beats 15, 31, 47; addr wraps 15->0 with no gap; single done pulse.
- Random backpressure (m_ready toggled ~50%), num_passes=2:
  - Received sequence equals ROM[0..15] twice; m_data stable during stalls; FIFO count never exceeds 2.
- m_ready=0 for 20 cycles after start:
  - Exactly 2 words buffered, rom issues stop.
  - On release, 16 words are delivered in order.
- num_passes=0 start -> no m_valid, busy stays 0, done pulses the next cycle.
- reset=0 asserted mid-pass (after 5 beats):
  - All outputs return to reset values the next cycle; no done pulse.
  - A new start then replays from word0.
